// File: rtl/pcs_tx_pkt_gen_pkg.sv
// Shared PCS definitions for the TX packet generator: FSM states, block-type flags,
// preamble/SFD word, frame length limits and a byte-wise CRC-32 helper.
package pcs_tx_pkt_gen_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_TERM,
        S_IPG
    } state_t;

    typedef struct packed {
        logic       ctrl;
        logic       idle;
        logic [1:0] start;
        logic       term;
        logic       err;
    } blk_flags_t;

    localparam blk_flags_t BLK_IDLE  = '{ctrl: 1'b1, idle: 1'b1, start: 2'b00, term: 1'b0, err: 1'b0};
    localparam blk_flags_t BLK_START = '{ctrl: 1'b1, idle: 1'b0, start: 2'b01, term: 1'b0, err: 1'b0};
    localparam blk_flags_t BLK_DATA  = '{ctrl: 1'b0, idle: 1'b0, start: 2'b00, term: 1'b0, err: 1'b0};
    localparam blk_flags_t BLK_TERM  = '{ctrl: 1'b1, idle: 1'b0, start: 2'b00, term: 1'b1, err: 1'b0};

    // Seven 0x55 preamble bytes in lanes 0..6, SFD 0xD5 in lane 7
    localparam logic [63:0] PREAMBLE_SFD = 64'hD555_5555_5555_5555;

    localparam logic [10:0] MIN_FRAME_LEN = 11'd64;
    localparam logic [10:0] MAX_FRAME_LEN = 11'd1518;

    function automatic logic [10:0] clamp_len(input logic [10:0] len);
        if (len < MIN_FRAME_LEN)
            return MIN_FRAME_LEN;
        else if (len > MAX_FRAME_LEN)
            return MAX_FRAME_LEN;
        return len;
    endfunction

    function automatic logic [3:0] clamp_ipg(input logic [3:0] ipg);
        return (ipg == 4'd0) ? 4'd1 : ipg;
    endfunction

    // Reflected CRC-32 (poly 0x04C11DB7), one byte per call
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        c = crc ^ {24'd0, b};
        for (int i = 0; i < 8; i++)
            c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        return c;
    endfunction

endpackage

// File: rtl/pcs_pkt_gen_crc32.sv
// Keep-masked 64-bit CRC-32 accumulator for the packet generator FCS.
// Only present when PCS_PKT_GEN_FCS_EN is defined.
`ifdef PCS_PKT_GEN_FCS_EN
module pcs_pkt_gen_crc32
    import pcs_tx_pkt_gen_pkg::*;
#(
    parameter  int DATA_W = 64,
    localparam int KEEP_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              i_init,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_data,
    input  logic [KEEP_W-1:0] i_keep,
    output logic [31:0]       o_crc_next
);

    logic [31:0] r_crc;

    always_comb begin
        o_crc_next = r_crc;
        for (int j = 0; j < KEEP_W; j++) begin
            if (i_keep[j])
                o_crc_next = crc32_byte(o_crc_next, i_data[8*j +: 8]);
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset)
            r_crc <= 32'hFFFF_FFFF;
        else if (i_init)
            r_crc <= 32'hFFFF_FFFF;
        else if (i_en)
            r_crc <= o_crc_next;
    end

endmodule
`endif

// File: rtl/pcs_tx_pkt_gen.sv
// 10G PCS TX test-frame generator: START / DATA / TERM / IPG blocks with a ready handshake.
// Define PCS_PKT_GEN_FCS_EN to replace the last 4 frame bytes with a real CRC-32 FCS.
module pcs_tx_pkt_gen
    import pcs_tx_pkt_gen_pkg::*;
#(
    parameter  int IS_10G      = 1,
    parameter  int DATA_W      = 64,
    localparam int KEEP_W      = DATA_W / 8,
    localparam int LANE0_CNT_N = 2
) (
    input  logic                   clk,
    input  logic                   nreset,
    input  logic                   en_i,
    input  logic [10:0]            len_i,
    input  logic [3:0]             ipg_i,
    input  logic                   ready_i,
    output logic                   ctrl_v_o,
    output logic                   idle_v_o,
    output logic                   term_v_o,
    output logic                   err_v_o,
    output logic [LANE0_CNT_N-1:0] start_v_o,
    output logic [DATA_W-1:0]      data_o,
    output logic [KEEP_W-1:0]      keep_o,
    output logic [31:0]            frame_cnt_o
);

    state_t            r_state;
    blk_flags_t        r_flags;
    logic [DATA_W-1:0] r_data;
    logic [KEEP_W-1:0] r_keep;
    logic [31:0]       r_frame_cnt;
    logic [10:0]       r_len;
    logic [10:0]       r_byte_idx;
    logic [3:0]        r_ipg;
    logic [3:0]        r_ipg_cnt;

    logic              w_go;
    logic              w_load_start;
    logic              w_load_payload;
    logic [10:0]       w_remain;
    logic              w_full;
    logic [3:0]        w_lane_n;
    logic [DATA_W-1:0] w_pat_data;
    logic [DATA_W-1:0] w_word_data;
    logic [KEEP_W-1:0] w_word_keep;

    assign w_go           = en_i && (IS_10G == 1);
    assign w_load_start   = ((r_state == S_IDLE) && w_go) ||
                            ((r_state == S_IPG) && (r_ipg_cnt == 4'd0) && w_go);
    assign w_load_payload = (r_state == S_START) || (r_state == S_DATA);

    // r_byte_idx always points at the first byte of the next payload word
    assign w_remain = r_len - r_byte_idx;
    assign w_full   = (w_remain >= 11'(KEEP_W));
    assign w_lane_n = w_full ? 4'(KEEP_W) : w_remain[3:0];

`ifdef PCS_PKT_GEN_FCS_EN
    logic [KEEP_W-1:0] w_crc_keep;
    logic [31:0]       w_crc_next;
    logic [31:0]       w_fcs;
    logic [10:0]       w_fcs_base;
    logic [1:0]        w_fcs_sel;

    assign w_fcs_base = r_len - 11'd4;
    assign w_fcs      = ~w_crc_next;

    pcs_pkt_gen_crc32 #(
        .DATA_W (DATA_W)
    ) u_crc (
        .clk        (clk),
        .nreset     (nreset),
        .i_init     (ready_i && w_load_start),
        .i_en       (ready_i && w_load_payload),
        .i_data     (w_pat_data),
        .i_keep     (w_crc_keep),
        .o_crc_next (w_crc_next)
    );
`endif

    always_comb begin
        w_pat_data  = '0;
        w_word_keep = '0;
`ifdef PCS_PKT_GEN_FCS_EN
        w_crc_keep  = '0;
`endif
        for (int j = 0; j < KEEP_W; j++) begin
            if (4'(j) < w_lane_n) begin
                w_word_keep[j]       = 1'b1;
                w_pat_data[8*j +: 8] = 8'(r_byte_idx + 11'(j));
`ifdef PCS_PKT_GEN_FCS_EN
                w_crc_keep[j]        = (r_byte_idx + 11'(j)) < w_fcs_base;
`endif
            end
        end
    end

`ifdef PCS_PKT_GEN_FCS_EN
    // Lanes that are valid but excluded from the CRC are the FCS lanes, LSB first
    always_comb begin
        w_word_data = w_pat_data;
        w_fcs_sel   = '0;
        for (int j = 0; j < KEEP_W; j++) begin
            w_fcs_sel = 2'(r_byte_idx + 11'(j) - w_fcs_base);
            if (w_word_keep[j] && !w_crc_keep[j])
                w_word_data[8*j +: 8] = w_fcs[{w_fcs_sel, 3'b000} +: 8];
        end
    end
`else
    assign w_word_data = w_pat_data;
`endif

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state     <= S_IDLE;
            r_flags     <= BLK_IDLE;
            r_data      <= '0;
            r_keep      <= '0;
            r_frame_cnt <= '0;
            r_len       <= MIN_FRAME_LEN;
            r_byte_idx  <= '0;
            r_ipg       <= 4'd1;
            r_ipg_cnt   <= '0;
        end else if (ready_i) begin
            if (w_load_start) begin
                r_state    <= S_START;
                r_flags    <= BLK_START;
                r_data     <= DATA_W'(PREAMBLE_SFD);
                r_keep     <= '1;
                r_len      <= clamp_len(len_i);
                r_ipg      <= clamp_ipg(ipg_i);
                r_byte_idx <= '0;
            end else if (w_load_payload) begin
                r_state    <= w_full ? S_DATA : S_TERM;
                r_flags    <= w_full ? BLK_DATA : BLK_TERM;
                r_data     <= w_word_data;
                r_keep     <= w_word_keep;
                r_byte_idx <= r_byte_idx + 11'(KEEP_W);
            end else begin
                case (r_state)
                    S_TERM: begin
                        r_state     <= S_IPG;
                        r_flags     <= BLK_IDLE;
                        r_data      <= '0;
                        r_keep      <= '0;
                        r_ipg_cnt   <= r_ipg - 4'd1;
                        r_frame_cnt <= r_frame_cnt + 32'd1;
                    end
                    S_IPG: begin
                        if (r_ipg_cnt == 4'd0)
                            r_state <= S_IDLE;
                        else
                            r_ipg_cnt <= r_ipg_cnt - 4'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign ctrl_v_o    = r_flags.ctrl;
    assign idle_v_o    = r_flags.idle;
    assign start_v_o   = r_flags.start;
    assign term_v_o    = r_flags.term;
    assign err_v_o     = r_flags.err;
    assign data_o      = r_data;
    assign keep_o      = r_keep;
    assign frame_cnt_o = r_frame_cnt;

endmodule

// File: tb/tb_pcs_tx_pkt_gen.sv
// Scoreboard bench for pcs_tx_pkt_gen: frames are modelled as byte arrays, expanded into
// expected words and checked by a monitor on every accepted word.
`timescale 1ns/1ps
module tb_pcs_tx_pkt_gen;

    logic        clk = 1'b0;
    logic        nreset;
    logic        en_i;
    logic [10:0] len_i;
    logic [3:0]  ipg_i;
    logic        ready_i;
    logic        ctrl_v_o;
    logic        idle_v_o;
    logic        term_v_o;
    logic        err_v_o;
    logic [1:0]  start_v_o;
    logic [63:0] data_o;
    logic [7:0]  keep_o;
    logic [31:0] frame_cnt_o;

    typedef struct {
        logic        ctrl;
        logic        idle;
        logic [1:0]  start;
        logic        term;
        logic        err;
        logic [63:0] data;
        logic [7:0]  keep;
        logic [31:0] cnt;
        bit          lead;
    } word_t;

    word_t       expQ[$];
    word_t       monExp;
    int          compared   = 0;
    int          mismatched = 0;
    int          wordNo     = 0;
    bit          monOn      = 1'b0;
    logic [31:0] lastCnt    = '0;
    logic [31:0] modelCnt   = '0;

    pcs_tx_pkt_gen #(
        .IS_10G (1),
        .DATA_W (64)
    ) dut (
        .clk         (clk),
        .nreset      (nreset),
        .en_i        (en_i),
        .len_i       (len_i),
        .ipg_i       (ipg_i),
        .ready_i     (ready_i),
        .ctrl_v_o    (ctrl_v_o),
        .idle_v_o    (idle_v_o),
        .term_v_o    (term_v_o),
        .err_v_o     (err_v_o),
        .start_v_o   (start_v_o),
        .data_o      (data_o),
        .keep_o      (keep_o),
        .frame_cnt_o (frame_cnt_o)
    );

    always #5 clk = ~clk;

    function automatic word_t mkWord(input logic c, input logic i, input logic [1:0] s,
                                     input logic t, input logic [63:0] d, input logic [7:0] k,
                                     input logic [31:0] n);
        word_t w;
        w.ctrl  = c;
        w.idle  = i;
        w.start = s;
        w.term  = t;
        w.err   = 1'b0;
        w.data  = d;
        w.keep  = k;
        w.cnt   = n;
        w.lead  = 1'b0;
        return w;
    endfunction

    function automatic word_t idleWord(input logic [31:0] n);
        return mkWord(1'b1, 1'b1, 2'b00, 1'b0, 64'd0, 8'h00, n);
    endfunction

    // Bit-serial reflected CRC-32 reference
    function automatic logic [31:0] refCrc(input byte unsigned b[], input int n);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            for (int bitIdx = 0; bitIdx < 8; bitIdx++) begin
                fb = c[0] ^ b[i][bitIdx];
                c  = c >> 1;
                if (fb)
                    c = c ^ 32'hEDB8_8320;
            end
        end
        return ~c;
    endfunction

    task automatic checkOutput(input string name, input word_t e);
        compared++;
        if (ctrl_v_o !== e.ctrl || idle_v_o !== e.idle || start_v_o !== e.start ||
            term_v_o !== e.term || err_v_o !== e.err || data_o !== e.data ||
            keep_o !== e.keep || frame_cnt_o !== e.cnt) begin
            mismatched++;
            $display("[TB] FAIL %s @%0t: got ctrl=%0b idle=%0b start=%b term=%0b err=%0b data=%h keep=%h cnt=%0d, expected ctrl=%0b idle=%0b start=%b term=%0b err=%0b data=%h keep=%h cnt=%0d",
                     name, $time, ctrl_v_o, idle_v_o, start_v_o, term_v_o, err_v_o, data_o, keep_o,
                     frame_cnt_o, e.ctrl, e.idle, e.start, e.term, e.err, e.data, e.keep, e.cnt);
        end
    endtask

    // Expands nFrames identical frames into the accepted-word sequence the DUT must produce
    task automatic pushFrames(input int lenEff, input int ipgEff, input int nFrames);
        byte unsigned fb[];
        logic [31:0]  crc;
        logic [31:0]  base;
        logic [63:0]  d;
        word_t        w;
        int           nData;
        int           nTail;
        fb = new[lenEff];
        for (int k = 0; k < lenEff; k++)
            fb[k] = 8'(k);
`ifdef PCS_PKT_GEN_FCS_EN
        crc = refCrc(fb, lenEff - 4);
        for (int i = 0; i < 4; i++)
            fb[lenEff - 4 + i] = crc[8*i +: 8];
`else
        crc = '0;
`endif
        nData = lenEff / 8;
        nTail = lenEff % 8;
        for (int f = 0; f < nFrames; f++) begin
            base   = modelCnt + 32'(f);
            w      = mkWord(1'b1, 1'b0, 2'b01, 1'b0, 64'hD555_5555_5555_5555, 8'hFF, base);
            w.lead = (f == 0);
            expQ.push_back(w);
            for (int dw = 0; dw < nData; dw++) begin
                d = '0;
                for (int j = 0; j < 8; j++)
                    d[8*j +: 8] = fb[8*dw + j];
                expQ.push_back(mkWord(1'b0, 1'b0, 2'b00, 1'b0, d, 8'hFF, base));
            end
            d = '0;
            for (int j = 0; j < nTail; j++)
                d[8*j +: 8] = fb[8*nData + j];
            expQ.push_back(mkWord(1'b1, 1'b0, 2'b00, 1'b1, d, 8'((1 << nTail) - 1), base));
            for (int g = 0; g < ipgEff; g++)
                expQ.push_back(idleWord(base + 32'd1));
        end
        modelCnt = modelCnt + 32'(nFrames);
    endtask

    // readyMode: 0 = always ready, 1 = toggle every cycle, 2 = random
    task automatic applyStimulus(input int lenReq, input int ipgReq, input int nFrames,
                                 input int readyMode, input int dropWord);
        int lenEff;
        int ipgEff;
        int period;
        int dropAt;
        int endAcc;
        int acc;
        int cyc;
        int drop;
        bit rdy;
        bit tog;
        lenEff = (lenReq < 64) ? 64 : ((lenReq > 1518) ? 1518 : lenReq);
        ipgEff = (ipgReq == 0) ? 1 : ipgReq;
        period = 2 + lenEff / 8 + ipgEff;
        drop   = (dropWord < 1) ? 1 : ((dropWord > period - 1) ? period - 1 : dropWord);
        dropAt = 1 + (nFrames - 1) * period + drop;
        endAcc = 1 + nFrames * period;
        acc    = 0;
        cyc    = 0;
        tog    = 1'b0;
        len_i  = 11'(lenReq);
        ipg_i  = 4'(ipgReq);
        pushFrames(lenEff, ipgEff, nFrames);
        en_i = 1'b1;
        while (acc < endAcc) begin
            case (readyMode)
                0:       rdy = 1'b1;
                1:       begin rdy = tog; tog = ~tog; end
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            if (cyc > 2 * endAcc)
                rdy = 1'b1;
            ready_i = rdy;
            @(posedge clk);
            #1;
            cyc++;
            if (rdy) begin
                acc++;
                if (acc == dropAt)
                    en_i = 1'b0;
            end
        end
        en_i    = 1'b0;
        ready_i = 1'b1;
        repeat (6) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (monOn && nreset === 1'b1 && ready_i === 1'b1) begin
            if (expQ.size() == 0) begin
                checkOutput("idleGap", idleWord(lastCnt));
            end else if (expQ[0].lead) begin
                checkOutput("leadIdle", idleWord(expQ[0].cnt));
                expQ[0].lead = 1'b0;
            end else begin
                monExp  = expQ.pop_front();
                lastCnt = monExp.cnt;
                checkOutput($sformatf("word%0d", wordNo), monExp);
            end
            wordNo++;
        end
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        nreset  = 1'b0;
        en_i    = 1'b0;
        ready_i = 1'b0;
        len_i   = 11'd64;
        ipg_i   = 4'd2;
        #12;
        checkOutput("resetState", idleWord(32'd0));
        @(negedge clk);
        nreset = 1'b1;
        @(posedge clk);
        #1;
        ready_i = 1'b1;
        monOn   = 1'b1;

        applyStimulus(64, 2, 3, 0, 5);
        applyStimulus(67, 1, 2, 0, 4);
        applyStimulus(64, 2, 2, 1, 6);
        applyStimulus(67, 3, 2, 1, 6);
        applyStimulus(20, 0, 1, 0, 3);
        applyStimulus(2000, 15, 1, 2, 50);
        for (int t = 0; t < 6; t++)
            applyStimulus($urandom_range(0, 300), $urandom_range(0, 15), $urandom_range(1, 3),
                          $urandom_range(0, 2), $urandom_range(1, 40));

        // Abandon a frame mid-DATA: outputs must go idle immediately and the count clears
        monOn   = 1'b0;
        len_i   = 11'd64;
        ipg_i   = 4'd2;
        en_i    = 1'b1;
        ready_i = 1'b1;
        repeat (4) @(posedge clk);
        #3;
        nreset = 1'b0;
        #1;
        checkOutput("resetMidData", idleWord(32'd0));
        en_i = 1'b0;
        expQ.delete();
        lastCnt  = '0;
        modelCnt = '0;
        @(negedge clk);
        nreset = 1'b1;
        @(posedge clk);
        #1;
        monOn = 1'b1;
        applyStimulus(64, 2, 1, 2, 3);
        applyStimulus(71, 4, 2, 0, 9);

        monOn = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
